// File: rtl/wide_add_seq.sv
// Multi-word add/subtract sequencer: drives one external 16-bit adder slice for WORDS
// cycles, LSW first, carry chained through a register. Optional: WIDE_ADD_SEQ_OVF_EN.
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic [15:0]           add_x,
  output logic [15:0]           add_y,
  output logic                  add_cin,
  input  logic [15:0]           add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy,
  output logic [1:0]            dbg_state
`ifdef WIDE_ADD_SEQ_OVF_EN
  ,
  output logic                  out_ovf
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and ready is a pure function of the FSM state.

  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q, b_q, sum_q, sum_d;
  logic [W-1:0]    out_sum_q;
  logic            out_cout_q;
  logic            accept;
  logic            last_word;

  assign accept    = in_valid && (state_q == IDLE);
  assign last_word = (idx_q == IW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    dbg_state = state_q;
    add_x     = 16'd0;
    add_y     = 16'd0;
    add_cin   = 1'b0;
    if (state_q == RUN) begin
      add_x   = a_q[{idx_q, 4'b0000} +: 16];
      add_y   = b_q[{idx_q, 4'b0000} +: 16];
      add_cin = carry_q;
    end
  end

  // Working sum with the current slice result merged in; the final word is taken
  // from here so the published result updates in one step on entry to DONE.
  always_comb begin
    sum_d = sum_q;
    if (state_q == RUN) sum_d[{idx_q, 4'b0000} +: 16] = add_sum;
  end

`ifdef WIDE_ADD_SEQ_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                        ovf_q <= 1'b0;
    else if (state_q == RUN && last_word)
      ovf_q <= (add_x[15] ^ add_y[15] ^ add_sum[15]) ^ add_cout;
  end
  assign out_ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub ? 1'b1 : in_cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= add_cout;
          if (last_word) begin
            out_sum_q  <= sum_d;
            out_cout_q <= add_cout;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = out_sum_q;
  assign out_cout = out_cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq (WORDS=4) with a behavioural adder slice; define
// WIDE_ADD_SEQ_OVF_EN on both files to exercise the overflow output.
module tb_wide_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready;
  logic [W-1:0]   in_a, in_b;
  logic           in_cin, in_sub;
  logic [15:0]    add_x, add_y, add_sum;
  logic           add_cin, add_cout;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_sum;
  logic           out_cout, busy;
  logic [1:0]     dbg_state;
`ifdef WIDE_ADD_SEQ_OVF_EN
  logic           out_ovf;
`endif

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [W-1:0]   exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // External 16-bit adder slice
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {16'd0, add_cin};

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy),
`ifdef WIDE_ADD_SEQ_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_before_send", W'(in_ready), W'(1));
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called right after the acceptance edge; returns edges until out_valid and the add_cin trace.
  task automatic wait_done(output int edges, output logic [3:0] cins);
    edges = 0;
    cins  = 4'b0000;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (edges < 4) cins[edges] = add_cin;
      if (edges >= 20) begin
        check_eq("out_valid_timeout", W'(0), W'(1));
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq("out_valid_after_hs", W'(out_valid), W'(0));
    check_eq("in_ready_after_hs", W'(in_ready), W'(1));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input logic [3:0] exp_cins);
    int         edges;
    logic [3:0] cins;
    exp_q.push_back(exp_sum);
    send_req(a, b, cin, sub);
    wait_done(edges, cins);
    check_eq({name, "_latency"}, W'(edges), W'(4));
    check_eq({name, "_sum"}, out_sum, exp_q.pop_front());
    check_eq({name, "_cout"}, W'(out_cout), W'(exp_cout));
    check_eq({name, "_cin_trace"}, W'(cins), W'(exp_cins));
`ifdef WIDE_ADD_SEQ_OVF_EN
    check_eq({name, "_ovf"}, W'(out_ovf), W'(exp_ovf));
`else
    if (exp_ovf) $display("note: %s expects overflow, feature not built", name);
`endif
    take_result();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         edges, vcount;
    logic [3:0] cins;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_in_ready", W'(in_ready), W'(1));
    check_eq("rst_out_valid", W'(out_valid), W'(0));
    check_eq("rst_busy", W'(busy), W'(0));
    check_eq("rst_out_sum", out_sum, W'(0));
    check_eq("rst_out_cout", W'(out_cout), W'(0));
    check_eq("rst_state", W'(dbg_state), W'(0));

    run_op("carry32", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0001_0000_0000, 1'b0, 1'b0, 4'b0110);
    run_op("ripple_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
           64'h0, 1'b1, 1'b0, 4'b1111);
    run_op("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'b0001);
    run_op("sub_7_5", 64'd7, 64'd5, 1'b1, 1'b1,
           64'h2, 1'b1, 1'b0, 4'b1111);
`ifdef WIDE_ADD_SEQ_OVF_EN
    run_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b1110);
    run_op("ovf_none", 64'd3, 64'd4, 1'b0, 1'b0,
           64'd7, 1'b0, 1'b0, 4'b0000);
`endif

    // Backpressure: result held while a new request waits
    exp_q.push_back(64'h2345);
    send_req(64'h1234, 64'h1111, 1'b0, 1'b0);
    wait_done(edges, cins);
    check_eq("bp_first_sum", out_sum, exp_q.pop_front());
    in_a = 64'd10; in_b = 64'd20; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_hold_valid", W'(out_valid), W'(1));
      check_eq("bp_hold_in_ready", W'(in_ready), W'(0));
      check_eq("bp_hold_sum", out_sum, 64'h2345);
      check_eq("bp_hold_cout", W'(out_cout), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq("bp_idle_in_ready", W'(in_ready), W'(1));
    check_eq("bp_idle_out_valid", W'(out_valid), W'(0));
    check_eq("bp_idle_sum_kept", out_sum, 64'h2345);
    exp_q.push_back(64'd30);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(edges, cins);
    check_eq("bp_second_latency", W'(edges), W'(4));
    check_eq("bp_second_sum", out_sum, exp_q.pop_front());
    take_result();

    // Reset mid-RUN at idx=2
    send_req(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check_eq("mid_run_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_state", W'(dbg_state), W'(0));
    check_eq("midrst_out_valid", W'(out_valid), W'(0));
    check_eq("midrst_busy", W'(busy), W'(0));
    check_eq("midrst_in_ready", W'(in_ready), W'(1));
    check_eq("midrst_out_sum", out_sum, W'(0));
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check_eq("midrst_no_stale", W'(vcount), W'(0));

    check_eq("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
